// File: rtl/dcache_pkg.sv
// Shared types and width helpers for the direct-mapped data cache.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package dcache_pkg;

  localparam int WORD_SIZE = 16;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    FILL      = 2'd2
  } state_t;

  function automatic int offsetWidth(input int wordsPerLine);
    return $clog2(wordsPerLine);
  endfunction

  function automatic int indexWidth(input int numLines);
    return $clog2(numLines);
  endfunction

  function automatic int tagWidth(input int wordSize, input int numLines, input int wordsPerLine);
    return wordSize - $clog2(numLines) - $clog2(wordsPerLine);
  endfunction

endpackage

// File: rtl/dcache_line_array.sv
// Tag/valid/dirty/data storage for the direct-mapped cache, one read port.
// Latency: combinational read, writes land at the next rising edge.
// Backpressure: none; writes are always accepted, valid/dirty clear asynchronously.
module dcache_line_array #(
  parameter int WORD_SIZE      = dcache_pkg::WORD_SIZE,
  parameter int NUM_LINES      = 4,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic                                                       Clk,
  input  logic                                                       Reset_N,
  input  logic [dcache_pkg::indexWidth(NUM_LINES)-1:0]               rdIdx,
  input  logic [dcache_pkg::offsetWidth(WORDS_PER_LINE)-1:0]         rdOff,
  output logic                                                       rdValid,
  output logic                                                       rdDirty,
  output logic [dcache_pkg::tagWidth(WORD_SIZE, NUM_LINES, WORDS_PER_LINE)-1:0] rdTag,
  output logic [WORD_SIZE-1:0]                                       rdWord,
  input  logic                                                       wordWe,
  input  logic                                                       wordSetDirty,
  input  logic [dcache_pkg::indexWidth(NUM_LINES)-1:0]               wordIdx,
  input  logic [dcache_pkg::offsetWidth(WORDS_PER_LINE)-1:0]         wordOff,
  input  logic [WORD_SIZE-1:0]                                       wordData,
  input  logic                                                       lineWe,
  input  logic [dcache_pkg::indexWidth(NUM_LINES)-1:0]               lineIdx,
  input  logic [dcache_pkg::tagWidth(WORD_SIZE, NUM_LINES, WORDS_PER_LINE)-1:0] lineTag
);
  import dcache_pkg::*;

  localparam int OFF_W = offsetWidth(WORDS_PER_LINE);
  localparam int IDX_W = indexWidth(NUM_LINES);
  localparam int TAG_W = tagWidth(WORD_SIZE, NUM_LINES, WORDS_PER_LINE);

  logic [NUM_LINES-1:0] validQ;
  logic [NUM_LINES-1:0] dirtyQ;
  logic [TAG_W-1:0]     tagQ  [NUM_LINES];
  logic [WORD_SIZE-1:0] dataQ [NUM_LINES*WORDS_PER_LINE];

  assign rdValid = validQ[rdIdx];
  assign rdDirty = dirtyQ[rdIdx];
  assign rdTag   = tagQ[rdIdx];
  assign rdWord  = dataQ[{rdIdx, rdOff}];

  // Line state: a completed fill makes the line valid and clean, a store hit dirties it.
  always_ff @(posedge Clk or negedge Reset_N) begin
    if (!Reset_N) begin
      validQ <= '0;
      dirtyQ <= '0;
    end else begin
      if (lineWe) begin
        validQ[lineIdx] <= 1'b1;
        dirtyQ[lineIdx] <= 1'b0;
      end
      if (wordWe && wordSetDirty) begin
        dirtyQ[wordIdx] <= 1'b1;
      end
    end
  end

  // Tags and data are never reset; valid gates their use.
  always_ff @(posedge Clk) begin
    if (lineWe) begin
      tagQ[lineIdx] <= lineTag;
    end
    if (wordWe) begin
      dataQ[{wordIdx, wordOff}] <= wordData;
    end
  end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back write-allocate D-cache; optional hit/miss counters under DCACHE_STATS_EN.
// Latency: hits answer in the same cycle; a miss costs one memory handshake per word (evict then fill).
// Backpressure: d_stall rises combinationally on a miss and holds until the refill completes; memory paces via mem_ready.
module dcache_ctrl #(
  parameter int WORD_SIZE      = dcache_pkg::WORD_SIZE,
  parameter int NUM_LINES      = 4,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic                 Clk,
  input  logic                 Reset_N,
  input  logic                 d_readM,
  input  logic                 d_writeM,
  input  logic [WORD_SIZE-1:0] d_address,
  input  logic [WORD_SIZE-1:0] d_wdata,
  output logic [WORD_SIZE-1:0] d_rdata,
  output logic                 d_stall,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [WORD_SIZE-1:0] mem_address,
  output logic [WORD_SIZE-1:0] mem_wdata,
  input  logic [WORD_SIZE-1:0] mem_rdata,
  input  logic                 mem_ready
`ifdef DCACHE_STATS_EN
  ,
  output logic [15:0]          hit_count,
  output logic [15:0]          miss_count
`endif
);
  import dcache_pkg::*;

  localparam int OFF_W = offsetWidth(WORDS_PER_LINE);
  localparam int IDX_W = indexWidth(NUM_LINES);
  localparam int TAG_W = tagWidth(WORD_SIZE, NUM_LINES, WORDS_PER_LINE);

  state_t           state;
  logic [OFF_W-1:0] cnt;
  logic [TAG_W-1:0] missTag;
  logic [IDX_W-1:0] missIdx;

  logic [TAG_W-1:0] reqTag;
  logic [IDX_W-1:0] reqIdx;
  logic [OFF_W-1:0] reqOff;
  logic             req;
  logic             inIdle;
  logic             hit;
  logic             missStart;
  logic             lastWord;
  logic             fillBeat;

  logic [IDX_W-1:0]     arrIdx;
  logic [OFF_W-1:0]     arrOff;
  logic                 lineValid;
  logic                 lineDirty;
  logic [TAG_W-1:0]     lineTag;
  logic [WORD_SIZE-1:0] lineWord;

  assign reqTag = d_address[WORD_SIZE-1 -: TAG_W];
  assign reqIdx = d_address[OFF_W +: IDX_W];
  assign reqOff = d_address[OFF_W-1:0];
  assign req    = d_readM | d_writeM;
  assign inIdle = (state == IDLE);

  // While idle the array looks at the CPU address; during a miss it walks the latched line.
  assign arrIdx = inIdle ? reqIdx : missIdx;
  assign arrOff = inIdle ? reqOff : cnt;

  assign hit       = inIdle && lineValid && (lineTag == reqTag);
  assign missStart = inIdle && req && !hit;
  assign lastWord  = (cnt == OFF_W'(WORDS_PER_LINE - 1));
  assign fillBeat  = (state == FILL) && mem_req && mem_ready;

  assign d_rdata   = (hit && d_readM && !d_writeM) ? lineWord : '0;
  assign d_stall   = Reset_N && (!inIdle || missStart);
  assign mem_wdata = (state == WRITEBACK) ? lineWord : '0;

  dcache_line_array #(
    .WORD_SIZE      (WORD_SIZE),
    .NUM_LINES      (NUM_LINES),
    .WORDS_PER_LINE (WORDS_PER_LINE)
  ) u_lines (
    .Clk          (Clk),
    .Reset_N      (Reset_N),
    .rdIdx        (arrIdx),
    .rdOff        (arrOff),
    .rdValid      (lineValid),
    .rdDirty      (lineDirty),
    .rdTag        (lineTag),
    .rdWord       (lineWord),
    .wordWe       ((hit && d_writeM) || fillBeat),
    .wordSetDirty (inIdle),
    .wordIdx      (arrIdx),
    .wordOff      (arrOff),
    .wordData     (inIdle ? d_wdata : mem_rdata),
    .lineWe       (fillBeat && lastWord),
    .lineIdx      (missIdx),
    .lineTag      (missTag)
  );

  // Miss sequencer: optional eviction of the dirty victim, then refill, one word per mem_ready.
  always_ff @(posedge Clk or negedge Reset_N) begin
    if (!Reset_N) begin
      state       <= IDLE;
      cnt         <= '0;
      missTag     <= '0;
      missIdx     <= '0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_address <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (missStart) begin
            missTag <= reqTag;
            missIdx <= reqIdx;
            cnt     <= '0;
            mem_req <= 1'b1;
            if (lineValid && lineDirty) begin
              state       <= WRITEBACK;
              mem_we      <= 1'b1;
              mem_address <= {lineTag, reqIdx, {OFF_W{1'b0}}};
            end else begin
              state       <= FILL;
              mem_we      <= 1'b0;
              mem_address <= {reqTag, reqIdx, {OFF_W{1'b0}}};
            end
          end
        end
        WRITEBACK: begin
          if (mem_ready) begin
            if (lastWord) begin
              state       <= FILL;
              cnt         <= '0;
              mem_we      <= 1'b0;
              mem_address <= {missTag, missIdx, {OFF_W{1'b0}}};
            end else begin
              cnt         <= cnt + OFF_W'(1);
              mem_address <= mem_address + WORD_SIZE'(1);
            end
          end
        end
        FILL: begin
          if (mem_ready) begin
            if (lastWord) begin
              state       <= IDLE;
              cnt         <= '0;
              mem_req     <= 1'b0;
              mem_address <= '0;
            end else begin
              cnt         <= cnt + OFF_W'(1);
              mem_address <= mem_address + WORD_SIZE'(1);
            end
          end
        end
        default: begin
          state   <= IDLE;
          cnt     <= '0;
          mem_req <= 1'b0;
          mem_we  <= 1'b0;
        end
      endcase
    end
  end

`ifdef DCACHE_STATS_EN
  // Saturating counters of accepted hits and of miss launches.
  always_ff @(posedge Clk or negedge Reset_N) begin
    if (!Reset_N) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (req && hit && (hit_count != 16'hFFFF)) begin
        hit_count <= hit_count + 16'd1;
      end
      if (missStart && (miss_count != 16'hFFFF)) begin
        miss_count <= miss_count + 16'd1;
      end
    end
  end
`endif

endmodule
